// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: op bit positions,
// divider iteration count and FSM state encoding.
package muldiv_ctrl_pkg;

    localparam int MD_OP_WD  = 4;
    localparam int MD_MULT   = 3;
    localparam int MD_MULTU  = 2;
    localparam int MD_DIV    = 1;
    localparam int MD_DIVU   = 0;
    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL      = 2'd1,
        ST_DIV_ITER = 2'd2,
        ST_DIV_FIX  = 2'd3
    } md_state_e;

    // Magnitude as an unsigned value; 0x80000000 maps to 2^31.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? 32'(-v) : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_radix2.sv
// Iterative unsigned restoring divider: one quotient bit per step, operands
// loaded on start, everything cleared on clear or reset.
module muldiv_ctrl_div_radix2
    import muldiv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear,
    input  logic        start,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quo,
    output logic [31:0] rem
);

    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic [32:0] rem_sh;
    logic [32:0] diff;

    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvsr_d = dvsr_q;
        rem_sh = {rem_q, quo_q[31]};
        diff   = rem_sh - {1'b0, dvsr_q};
        if (clear) begin
            quo_d  = '0;
            rem_d  = '0;
            dvsr_d = '0;
        end else if (start) begin
            quo_d  = dividend;
            rem_d  = '0;
            dvsr_d = divisor;
        end else if (step) begin
            // Dividend bits shift out of quo_q into rem while quotient bits shift in.
            if (!diff[32]) begin
                rem_d = diff[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = rem_sh[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvsr_q <= dvsr_d;
        end
    end

    assign quo = quo_q;
    assign rem = rem_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: pipelined multiplier, iterative divider,
// MTHI/MTLO writes, flush, and busy/done status for the pipeline.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_STAGES = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [MD_OP_WD-1:0] req_op,
    input  logic [31:0]         req_src1,
    input  logic [31:0]         req_src2,
    input  logic                mt_hi_we,
    input  logic                mt_lo_we,
    input  logic [31:0]         mt_data,
    input  logic                flush,
    output logic                busy,
    output logic                done,
    output logic [31:0]         hi_rdata,
    output logic [31:0]         lo_rdata,
    output md_state_e           dbg_state
);

    // Handshake: an op transfers on a posedge where req_valid & req_ready & ~flush;
    // req_ready is high exactly in IDLE and req_* must be stable while req_valid is high.

    localparam int MUL_DEPTH = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;
    localparam int MUL_TAP   = (MUL_STAGES > 1) ? MUL_STAGES - 2 : 0;

    md_state_e   state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] dividend_q, dividend_d;
    logic        done_q, done_d, busy_q, busy_d, ready_q, ready_d;
    logic        quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;
    logic        div_zero_q, div_zero_d;
    logic [63:0] mul_pipe_q [MUL_DEPTH];
    logic [63:0] mul_pipe_d [MUL_DEPTH];

    logic        accept, op_onehot, op_mul, op_sdiv;
    logic [63:0] mul_a, mul_b, prod_c, mul_res;
    logic        div_start, div_step;
    logic [31:0] div_quo, div_rem, quo_fix, rem_fix;

    always_comb begin
        accept    = req_valid & ready_q & ~flush;
        op_onehot = $onehot(req_op);
        op_mul    = req_op[MD_MULT] | req_op[MD_MULTU];
        op_sdiv   = req_op[MD_DIV];
        mul_a     = req_op[MD_MULT] ? {{32{req_src1[31]}}, req_src1} : {32'd0, req_src1};
        mul_b     = req_op[MD_MULT] ? {{32{req_src2[31]}}, req_src2} : {32'd0, req_src2};
        prod_c    = mul_a * mul_b;
        mul_pipe_d[0] = prod_c;
        for (int i = 1; i < MUL_DEPTH; i++) begin
            mul_pipe_d[i] = mul_pipe_q[i-1];
        end
        mul_res = (MUL_STAGES == 1) ? prod_c : mul_pipe_q[MUL_TAP];
        quo_fix = quo_neg_q ? 32'(-div_quo) : div_quo;
        rem_fix = rem_neg_q ? 32'(-div_rem) : div_rem;
        div_step = (state_q == ST_DIV_ITER);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        dividend_d = dividend_q;
        quo_neg_d  = quo_neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;
        div_start  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mt_hi_we) hi_d = mt_data;
                if (mt_lo_we) lo_d = mt_data;
                if (accept && op_onehot) begin
                    if (op_mul) begin
                        if (MUL_STAGES == 1) begin
                            {hi_d, lo_d} = prod_c;
                            done_d       = 1'b1;
                        end else begin
                            state_d = ST_MUL;
                            cnt_d   = 6'(MUL_STAGES - 1);
                        end
                    end else begin
                        state_d    = ST_DIV_ITER;
                        cnt_d      = 6'(DIV_ITERS);
                        div_start  = 1'b1;
                        dividend_d = req_src1;
                        quo_neg_d  = op_sdiv & (req_src1[31] ^ req_src2[31]);
                        rem_neg_d  = op_sdiv & req_src1[31];
                        div_zero_d = (req_src2 == 32'd0);
                    end
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 6'd1) begin
                    state_d      = ST_IDLE;
                    {hi_d, lo_d} = mul_res;
                    done_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            ST_DIV_ITER: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) state_d = ST_DIV_FIX;
                end
            end
            ST_DIV_FIX: begin
                state_d = ST_IDLE;
                if (!flush) begin
                    // Divide by zero leaves the dividend in HI and all-ones in LO.
                    hi_d   = div_zero_q ? dividend_q : rem_fix;
                    lo_d   = div_zero_q ? 32'hFFFF_FFFF : quo_fix;
                    done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            dividend_q <= '0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            for (int i = 0; i < MUL_DEPTH; i++) mul_pipe_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            dividend_q <= dividend_d;
            quo_neg_q  <= quo_neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            for (int i = 0; i < MUL_DEPTH; i++) mul_pipe_q[i] <= mul_pipe_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            if (req_valid && ready_q && !flush)
                assert ($onehot(req_op)) else $warning("muldiv_ctrl: req_op not one-hot at accept, ignored");
            if (state_q != ST_IDLE)
                assert (!(mt_hi_we || mt_lo_we)) else $warning("muldiv_ctrl: MTHI/MTLO while busy, ignored");
        end
    end

    muldiv_ctrl_div_radix2 u_div (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (flush),
        .start    (div_start),
        .step     (div_step),
        .dividend (abs32(req_src1, op_sdiv)),
        .divisor  (abs32(req_src2, op_sdiv)),
        .quo      (div_quo),
        .rem      (div_rem)
    );

    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign hi_rdata  = hi_q;
    assign lo_rdata  = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed and random checks of muldiv_ctrl: results scoreboarded as {HI,LO},
// latency, busy/ready, MTHI/MTLO, flush and reset behaviour.
module tb_muldiv_ctrl;

    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b0100;
    localparam logic [3:0] OP_DIV   = 4'b0010;
    localparam logic [3:0] OP_DIVU  = 4'b0001;

    logic        clk, resetn;
    logic        req_valid, req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_src1, req_src2;
    logic        mt_hi_we, mt_lo_we;
    logic [31:0] mt_data;
    logic        flush, busy, done;
    logic [31:0] hi_rdata, lo_rdata;
    muldiv_ctrl_pkg::md_state_e dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    muldiv_ctrl #(.MUL_STAGES(2)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_src1  (req_src1),
        .req_src2  (req_src2),
        .mt_hi_we  (mt_hi_we),
        .mt_lo_we  (mt_lo_we),
        .mt_data   (mt_data),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .hi_rdata  (hi_rdata),
        .lo_rdata  (lo_rdata),
        .dbg_state (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, sq, sr;
        logic signed [63:0] sa64, sb64;
        logic [63:0] r;
        sa = a;
        sb = b;
        sa64 = sa;
        sb64 = sb;
        r = '0;
        if (op == OP_MULT) r = sa64 * sb64;
        else if (op == OP_MULTU) r = {32'd0, a} * {32'd0, b};
        else if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else if (op == OP_DIVU) r = {a % b, a / b};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else begin
            sq = sa / sb;
            sr = sa % sb;
            r = {sr, sq};
        end
        return r;
    endfunction

    // Drive one request in the current cycle; returns in cycle 1 after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit push);
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        if (push) exp_q.push_back(exp);
        tick(1);
        req_valid = 1'b0;
        req_op    = 4'd0;
    endtask

    task automatic wait_done(input string tag, input int start_cyc, input int exp_lat);
        int cyc;
        int busy_low;
        logic [63:0] e;
        cyc = start_cyc;
        busy_low = 0;
        while (done !== 1'b1 && cyc < exp_lat + 20) begin
            if (busy !== 1'b1) busy_low++;
            tick(1);
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " busy_gap"}, 32'(busy_low), 32'd0);
        check({tag, " ready_in_done"}, {31'd0, req_ready}, 32'd1);
        check({tag, " sb_nonempty"}, {31'd0, exp_q.size() != 0}, 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'd0;
        check({tag, " hi"}, hi_rdata, e[63:32]);
        check({tag, " lo"}, lo_rdata, e[31:0]);
    endtask

    initial begin
        logic [3:0]  ops [4];
        logic [3:0]  op;
        logic [31:0] a, b;
        int          pulses;
        ops[0] = OP_MULT; ops[1] = OP_MULTU; ops[2] = OP_DIV; ops[3] = OP_DIVU;

        resetn = 1'b0; req_valid = 1'b0; req_op = '0; req_src1 = '0; req_src2 = '0;
        mt_hi_we = 1'b0; mt_lo_we = 1'b0; mt_data = '0; flush = 1'b0;
        tick(3);
        check("reset hi", hi_rdata, 32'd0);
        check("reset lo", lo_rdata, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset ready", {31'd0, req_ready}, 32'd1);
        check("reset state", {30'd0, dbg_state}, 32'd0);
        resetn = 1'b1;
        tick(1);

        issue(OP_MULT, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1);
        check("mult busy c1", {31'd0, busy}, 32'd1);
        check("mult ready c1", {31'd0, req_ready}, 32'd0);
        wait_done("mult", 1, 2);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 1);
        wait_done("multu", 1, 2);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1);
        wait_done("div -7/2", 1, 34);
        issue(OP_DIVU, 32'd7, 32'd2, {32'd1, 32'd3}, 1);
        wait_done("divu 7/2", 1, 34);
        issue(OP_DIV, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1);
        wait_done("div 5/0", 1, 34);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1);
        wait_done("div min/-1", 1, 34);

        for (int i = 0; i < 6; i++) begin
            op = ops[$urandom_range(0, 3)];
            a  = $urandom;
            b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            issue(op, a, b, model(op, a, b), 1);
            wait_done("random", 1, (op[3] | op[2]) ? 2 : 34);
        end

        // mult, then divu accepted in the mult's done cycle
        issue(OP_MULT, 32'd3, 32'hFFFF_FFFC, model(OP_MULT, 32'd3, 32'hFFFF_FFFC), 1);
        wait_done("b2b mult", 1, 2);
        issue(OP_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 1);
        check("b2b hold hi", hi_rdata, 32'hFFFF_FFFF);
        check("b2b hold lo", lo_rdata, 32'hFFFF_FFF4);
        wait_done("b2b divu", 1, 34);

        // flush at cycle 10 of a div
        tick(1);
        issue(OP_DIV, 32'd1000, 32'd3, 64'd0, 0);
        tick(9);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("flush busy", {31'd0, busy}, 32'd0);
        check("flush ready", {31'd0, req_ready}, 32'd1);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1) pulses++;
            tick(1);
        end
        check("flush no done", 32'(pulses), 32'd0);
        check("flush hi kept", hi_rdata, 32'd2);
        check("flush lo kept", lo_rdata, 32'd14);

        mt_hi_we = 1'b1; mt_data = 32'h0000_1234;
        tick(1);
        mt_hi_we = 1'b0;
        check("mthi idle", hi_rdata, 32'h0000_1234);

        // MTLO while busy is ignored
        issue(OP_DIVU, 32'd9, 32'd4, {32'd1, 32'd2}, 1);
        tick(3);
        mt_lo_we = 1'b1; mt_data = 32'h0000_DEAD;
        tick(1);
        mt_lo_we = 1'b0;
        check("mtlo busy ignored", lo_rdata, 32'd14);
        wait_done("divu 9/4", 5, 34);

        // MTHI in the accept cycle, then the mult result overwrites it
        mt_hi_we = 1'b1; mt_data = 32'h0000_ABCD;
        issue(OP_MULTU, 32'd5, 32'd6, {32'd0, 32'd30}, 1);
        mt_hi_we = 1'b0;
        check("mt+accept hi", hi_rdata, 32'h0000_ABCD);
        wait_done("multu 5x6", 1, 2);

        // flush in IDLE: accept suppressed, MT still lands
        tick(1);
        req_valid = 1'b1; req_op = OP_DIV; req_src1 = 32'd8; req_src2 = 32'd2;
        flush = 1'b1; mt_hi_we = 1'b1; mt_lo_we = 1'b1; mt_data = 32'h0000_5555;
        tick(1);
        req_valid = 1'b0; req_op = '0; flush = 1'b0; mt_hi_we = 1'b0; mt_lo_we = 1'b0;
        check("idle flush busy", {31'd0, busy}, 32'd0);
        check("idle flush hi", hi_rdata, 32'h0000_5555);
        check("idle flush lo", lo_rdata, 32'h0000_5555);
        tick(2);
        check("idle flush still idle", {31'd0, busy}, 32'd0);
        check("idle flush no done", {31'd0, done}, 32'd0);

        // reset in the middle of a div
        issue(OP_DIV, 32'd77, 32'd5, 64'd0, 0);
        tick(5);
        resetn = 1'b0;
        tick(1);
        check("midreset hi", hi_rdata, 32'd0);
        check("midreset lo", lo_rdata, 32'd0);
        check("midreset ready", {31'd0, req_ready}, 32'd1);
        check("midreset busy", {31'd0, busy}, 32'd0);
        resetn = 1'b1;
        tick(1);

        issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1);
        wait_done("post-reset multu", 1, 2);
        tick(1);
        check("done one pulse", {31'd0, done}, 32'd0);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
